// File: rtl/lsm9ds1_resp_pkg.sv
// Shared types and constants for the LSM9DS1-style SPI register responder.
package lsm9ds1_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam int          REG_COUNT     = 128;
  localparam logic [6:0]  WHO_AM_I_ADDR = 7'h0F;

  function automatic logic [6:0] addr_inc(input logic [6:0] a);
    return a + 7'd1;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer with edge detect; edges are suppressed until the
// pipeline has refilled after reset so a level held across reset is not an edge.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_din,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic       r_meta;
  logic       r_sync;
  logic       r_prev;
  logic [1:0] r_prime;
  logic       w_armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta  <= RST_VAL;
      r_sync  <= RST_VAL;
      r_prev  <= RST_VAL;
      r_prime <= 2'd0;
    end else begin
      r_meta <= i_din;
      r_sync <= r_meta;
      r_prev <= r_sync;
      if (r_prime != 2'd3) r_prime <= r_prime + 2'd1;
    end
  end

  assign w_armed = (r_prime == 2'd3);
  assign o_q     = r_sync;
  assign o_rise  = w_armed &  r_sync & ~r_prev;
  assign o_fall  = w_armed & ~r_sync &  r_prev;

endmodule

// File: rtl/lsm9ds1_spi_responder.sv
// SPI mode-3 register-file responder modelled on the LSM9DS1 (128 x 8 registers).
// Define LSM9DS1_RESP_AUTOINC_EN to advance the address after every data byte.
module lsm9ds1_spi_responder
  import lsm9ds1_resp_pkg::*;
#(
  parameter logic [7:0] WHO_AM_I_VAL = 8'h68
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       ss_n,
  output logic       miso,
  output logic       miso_oe,
  input  logic       host_we,
  input  logic [6:0] host_addr,
  input  logic [7:0] host_wdata,
  output logic       wr_strobe,
  output logic [6:0] wr_addr,
  output logic [7:0] wr_data,
  output state_t     dbg_state
);

  // Handshake: no valid/ready; wr_strobe is a one-cycle pulse qualifying wr_addr/wr_data.

  logic w_sclk, w_sclk_rise, w_sclk_fall;
  logic w_mosi, w_mosi_rise, w_mosi_fall;
  logic w_ss_n, w_ss_rise, w_ss_fall;
  logic w_unused_edges;

  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_sclk (
    .clk(clk), .rst(rst), .i_din(sclk), .o_q(w_sclk), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );
  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .i_din(mosi), .o_q(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
  );
  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ss (
    .clk(clk), .rst(rst), .i_din(ss_n), .o_q(w_ss_n), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
  );

  assign w_unused_edges = ^{w_sclk, w_mosi_rise, w_mosi_fall, w_ss_rise};

  state_t     r_state, w_state_next;
  logic [2:0] r_bit_cnt;
  logic [6:0] r_rx_sr;
  logic [7:0] r_tx_sr;
  logic       r_skip;
  logic       r_rw;
  logic [6:0] r_addr;
  logic       r_wr_strobe;
  logic [6:0] r_wr_addr;
  logic [7:0] r_wr_data;
  logic [7:0] r_regs [REG_COUNT];

  logic       w_active;
  logic       w_byte_done;
  logic [7:0] w_rx_byte;
  logic [6:0] w_addr_next;
  logic       w_spi_we;

`ifdef LSM9DS1_RESP_AUTOINC_EN
  assign w_addr_next = addr_inc(r_addr);
`else
  assign w_addr_next = r_addr;
`endif

  assign w_active    = (r_state != ST_IDLE) && !w_ss_n;
  assign w_byte_done = w_active && w_sclk_rise && (r_bit_cnt == 3'd7);
  assign w_rx_byte   = {r_rx_sr, w_mosi};
  assign w_spi_we    = w_byte_done && (r_state == ST_DATA) && !r_rw;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_ss_n) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_ss_fall) w_state_next = ST_CMD;
        ST_CMD:  if (w_byte_done) w_state_next = ST_DATA;
        ST_DATA: w_state_next = ST_DATA;
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt   <= 3'd0;
      r_rx_sr     <= 7'd0;
      r_tx_sr     <= 8'hFF;
      r_skip      <= 1'b0;
      r_rw        <= 1'b0;
      r_addr      <= 7'd0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= 7'd0;
      r_wr_data   <= 8'd0;
    end else begin
      r_wr_strobe <= 1'b0;
      if (!w_active) begin
        r_bit_cnt <= 3'd0;
        r_skip    <= 1'b0;
      end else if (w_sclk_rise) begin
        r_rx_sr   <= w_rx_byte[6:0];
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (w_byte_done && r_state == ST_CMD) begin
          r_rw   <= w_rx_byte[7];
          r_addr <= w_rx_byte[6:0];
          if (w_rx_byte[7]) begin
            r_tx_sr <= r_regs[w_rx_byte[6:0]];
            r_skip  <= 1'b1;
          end
        end else if (w_byte_done) begin
          r_addr <= w_addr_next;
          if (r_rw) begin
            r_tx_sr <= r_regs[w_addr_next];
            r_skip  <= 1'b1;
          end else begin
            r_wr_strobe <= 1'b1;
            r_wr_addr   <= r_addr;
            r_wr_data   <= w_rx_byte;
          end
        end
      end else if (w_sclk_fall) begin
        // The fall right after a load is where the master starts the byte; bit 7 is already on miso.
        if (r_skip) r_skip <= 1'b0;
        else        r_tx_sr <= {r_tx_sr[6:0], 1'b1};
      end
    end
  end

  // SPI write is assigned last so it wins an address collision with the host port.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= 8'h00;
      r_regs[WHO_AM_I_ADDR] <= WHO_AM_I_VAL;
    end else begin
      if (host_we)  r_regs[host_addr] <= host_wdata;
      if (w_spi_we) r_regs[r_addr]    <= w_rx_byte;
    end
  end

  assign miso_oe   = (r_state == ST_DATA) && r_rw && !w_ss_n;
  assign miso      = miso_oe ? r_tx_sr[7] : 1'b1;
  assign wr_strobe = r_wr_strobe;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign dbg_state = r_state;

endmodule

// File: doc/lsm9ds1_spi_responder.md
LSM9DS1_SPI_RESPONDER -- requirements
Module: lsm9ds1_spi_responder

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high (ports clk, rst).
REQ-002 The block SHALL have parameter WHO_AM_I_VAL, default 8'h68, the reset value of register 0x0F.
REQ-003 The block SHALL have port clk  input  1  system clock; rising-edge only; frequency >= 8x SCLK.
REQ-004 The block SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 The block SHALL have port sclk  input  1  SPI clock from master; mode 3 (idles high).
REQ-006 The block SHALL have port mosi  input  1  SPI data from master.
REQ-007 The block SHALL have port ss_n  input  1  active-low slave select.
REQ-008 The block SHALL have port miso  output  1  SPI read data; 1 when miso_oe is 0.
REQ-009 The block SHALL have port miso_oe  output  1  miso drive enable for the top-level tri-state.
REQ-010 The block SHALL have ports host_we / host_addr / host_wdata  input  1/7/8  PL-side register preload (sensor data injection).
REQ-011 The block SHALL have ports wr_strobe / wr_addr / wr_data  output  1/7/8  one-cycle notice of each SPI register write.

Function
REQ-012 sclk, mosi and ss_n SHALL pass through 2-flop synchronizers; edges SHALL be detected on the synchronized sclk.
REQ-013 The register file SHALL hold 128 x 8 bits, addressed 0x00-0x7F.
REQ-014 FSM states SHALL be IDLE, CMD and DATA; IDLE->CMD on synchronized ss_n falling; any state->IDLE on synchronized ss_n high.
REQ-015 mosi SHALL be sampled MSB-first on each synchronized sclk rising edge; a 3-bit counter SHALL mark byte completion.
REQ-016 CMD byte: bit7 = rw (1 = read), bits6:0 = start address; on its 8th rising edge the FSM SHALL latch rw and addr and enter DATA.
REQ-017 Read: on CMD completion and on each DATA byte completion, tx_sr SHALL load reg[addr], with addr already advanced per REQ-019 for DATA bytes.
REQ-018 miso SHALL equal tx_sr[7]; tx_sr SHALL shift left on each sclk falling edge, except the first falling edge after a load.
REQ-019 Write: on DATA byte completion reg[addr] SHALL take the received byte, wr_strobe SHALL pulse one cycle with wr_addr/wr_data, then addr advances.
REQ-020 miso_oe SHALL be 1 only in DATA with rw = 1 and ss_n low.
REQ-021 ss_n deasserting mid-byte SHALL discard the partial byte: no register write, no wr_strobe.
REQ-022 host_we SHALL write reg[host_addr] in the same cycle; on a collision with an SPI write to the same address, the SPI write SHALL win.
REQ-023 A tx_sr load and a host write in the same cycle SHALL load the pre-write value.
REQ-024 Address arithmetic SHALL be 7-bit; 0x7F+1 SHALL wrap to 0x00.

Reset
REQ-025 On rst: FSM SHALL be IDLE, counters 0, tx_sr 8'hFF, miso 1, miso_oe 0, wr_strobe 0, wr_addr 0, wr_data 0.
REQ-026 On rst: all registers SHALL be 0 except reg[0x0F] = WHO_AM_I_VAL.
REQ-027 Reset asserted mid-transaction SHALL abort it; the block SHALL stay in IDLE until the next ss_n falling edge after reset release.

Configuration
REQ-028 With macro LSM9DS1_RESP_AUTOINC_EN defined, addr SHALL increment after every DATA byte (burst access).
REQ-029 Without LSM9DS1_RESP_AUTOINC_EN, addr SHALL stay fixed for the whole transaction; repeated bytes SHALL access the same register.

Structure
REQ-030 Package lsm9ds1_resp_pkg SHALL hold the FSM state encoding, the register count (128) and the WHO_AM_I address (0x0F).
REQ-031 Synchronizer plus edge detector SHALL be sub-module spi_sync_edge, instantiated once per SPI input.

Verification
REQ-032 Reset, then read of 0x8F -> miso returns 0x68; miso_oe is 1 only during the data byte.
REQ-033 Write 0x10, data 0xA5 -> reg[0x10] = 0xA5; wr_strobe one pulse with wr_addr 0x10, wr_data 0xA5.
REQ-034 Host preloads 0x28=0x11, 0x29=0x22, 0x2A=0x33; burst read 0xA8 with 3 bytes -> 0x11,0x22,0x33 (AUTOINC_EN); without the macro -> 0x11,0x11,0x11.
REQ-035 Write burst starting at 0x7F, data 0x01,0x02 -> reg[0x7F] = 0x01, reg[0x00] = 0x02 (wrap).
REQ-036 ss_n raised after 4 data bits of a write to 0x20 -> reg[0x20] unchanged, no wr_strobe, FSM IDLE.
REQ-037 Host write 0x30=0x55 in the same cycle as an SPI write of 0x30=0xAA -> reg[0x30] = 0xAA.
